cfu_mac: RTL and testbench

Parametrised custom function unit for the RISC-V core's CFU slot: packed-lane SIMD arithmetic plus a bank of dot-product accumulators. Sits in the EX stage behind the same `en_i` / `stall_o` / `rslt_o` contract as the existing single-cycle CFU. It adds multi-cycle operations that hold the pipeline. It also adds architectural state (accumulators) that persists across instructions.

---
 rtl/cfu_mac.sv | 182 ++++++++++++++++++
 tb/tb_cfu_mac.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_mac.sv
// cfu_mac: packed-lane SIMD ops plus a bank of dot-product accumulators for the CFU slot.
// Single-cycle ops resolve combinationally; DOT holds the pipeline for MUL_LAT cycles.
module cfu_mac #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned LANE_W  = 8,
   parameter int unsigned NACC    = 4,
   parameter int unsigned MUL_LAT = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            en_i,
   input  logic [2:0]      funct3_i,
   input  logic [6:0]      funct7_i,
   input  logic [XLEN-1:0] src1_i,
   input  logic [XLEN-1:0] src2_i,
   output logic            stall_o,
   output logic [XLEN-1:0] rslt_o
);

   localparam int unsigned LANES = XLEN / LANE_W;
   localparam int unsigned IDXW  = (NACC > 1) ? $clog2(NACC) : 1;
   localparam int unsigned PW    = 2 * LANE_W;
   localparam int unsigned SW    = (PW > XLEN) ? PW : XLEN;
   // IDLE supplies the first stall cycle, so BUSY only needs MUL_LAT-1 cycles.
   localparam logic [3:0]  CntInit = (MUL_LAT >= 2) ? 4'(MUL_LAT - 2) : 4'd0;

   localparam logic [2:0] OpOr     = 3'd0;
   localparam logic [2:0] OpPadd   = 3'd1;
   localparam logic [2:0] OpPsat   = 3'd2;
   localparam logic [2:0] OpDot    = 3'd3;
   localparam logic [2:0] OpAccRd  = 3'd4;
   localparam logic [2:0] OpAccClr = 3'd5;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e            r_state, w_state_d;
   logic [3:0]        r_cnt, w_cnt_d;
   logic [XLEN-1:0]   r_src1, r_src2;
   logic [IDXW-1:0]   r_idx;
   logic [XLEN-1:0]   r_acc [NACC];

   logic [IDXW-1:0]   w_idx;
   logic              w_capture;
   logic              w_acc_we;
   logic [IDXW-1:0]   w_acc_widx;
   logic [XLEN-1:0]   w_acc_wdata;
   logic [XLEN-1:0]   w_padd, w_psat, w_dot;
   logic [LANE_W-1:0] w_la, w_lb;
   logic [LANE_W:0]   w_usum, w_ssum;
   logic signed [LANE_W-1:0] w_pa, w_pb;
   logic signed [PW-1:0]     w_prod;
   logic signed [SW-1:0]     w_prod_ext, w_sum_wide;
   logic              w_unused_f7;

   assign w_idx       = funct7_i[IDXW-1:0];
   assign w_unused_f7 = ^funct7_i;

   // Per-lane wrapping add and signed saturating add on the live operands.
   always_comb begin
      w_padd = '0;
      w_psat = '0;
      w_la   = '0;
      w_lb   = '0;
      w_usum = '0;
      w_ssum = '0;
      for (int l = 0; l < LANES; l++) begin
         w_la   = src1_i[l*LANE_W +: LANE_W];
         w_lb   = src2_i[l*LANE_W +: LANE_W];
         w_usum = {1'b0, w_la} + {1'b0, w_lb};
         w_ssum = {w_la[LANE_W-1], w_la} + {w_lb[LANE_W-1], w_lb};
         w_padd[l*LANE_W +: LANE_W] = w_usum[LANE_W-1:0];
         // Overflow when the extra sign bit disagrees with the lane sign bit.
         if (w_ssum[LANE_W] != w_ssum[LANE_W-1]) begin
            w_psat[l*LANE_W +: LANE_W] = w_ssum[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                                        : {1'b0, {(LANE_W-1){1'b1}}};
         end else begin
            w_psat[l*LANE_W +: LANE_W] = w_ssum[LANE_W-1:0];
         end
      end
   end

   // Signed dot product of the captured operands, sign-extended and summed modulo 2^XLEN.
   always_comb begin
      w_sum_wide = '0;
      w_pa       = '0;
      w_pb       = '0;
      w_prod     = '0;
      w_prod_ext = '0;
      for (int l = 0; l < LANES; l++) begin
         w_pa       = r_src1[l*LANE_W +: LANE_W];
         w_pb       = r_src2[l*LANE_W +: LANE_W];
         w_prod     = w_pa * w_pb;
         w_prod_ext = w_prod;
         w_sum_wide = w_sum_wide + w_prod_ext;
      end
      w_dot = w_sum_wide[XLEN-1:0];
   end

   // Opcode decode, DOT sequencing and accumulator write request.
   always_comb begin
      w_state_d   = r_state;
      w_cnt_d     = r_cnt;
      stall_o     = 1'b0;
      rslt_o      = '0;
      w_capture   = 1'b0;
      w_acc_we    = 1'b0;
      w_acc_widx  = w_idx;
      w_acc_wdata = '0;
      unique case (r_state)
         StIdle: begin
            if (en_i) begin
               case (funct3_i)
                  OpOr:     rslt_o = src1_i | src2_i;
                  OpPadd:   rslt_o = w_padd;
                  OpPsat:   rslt_o = w_psat;
                  OpDot: begin
                     stall_o   = 1'b1;
                     w_capture = 1'b1;
                     w_cnt_d   = CntInit;
                     w_state_d = (MUL_LAT <= 1) ? StDone : StBusy;
                  end
                  OpAccRd:  rslt_o = r_acc[w_idx];
                  OpAccClr: begin
                     rslt_o      = r_acc[w_idx];
                     w_acc_we    = 1'b1;
                     w_acc_wdata = '0;
                  end
                  default:  rslt_o = '0;
               endcase
            end
         end
         StBusy: begin
            if (!en_i) begin
               w_state_d = StIdle;
            end else begin
               stall_o = 1'b1;
               if (r_cnt == 4'd0) begin
                  w_state_d = StDone;
               end else begin
                  w_cnt_d = r_cnt - 4'd1;
               end
            end
         end
         StDone: begin
            w_state_d = StIdle;
            if (en_i) begin
               rslt_o      = r_acc[r_idx] + w_dot;
               w_acc_we    = 1'b1;
               w_acc_widx  = r_idx;
               w_acc_wdata = r_acc[r_idx] + w_dot;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // State, captured operands and accumulator bank; reset clears everything.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= StIdle;
         r_cnt   <= 4'd0;
         r_src1  <= '0;
         r_src2  <= '0;
         r_idx   <= '0;
         for (int i = 0; i < NACC; i++) begin
            r_acc[i] <= '0;
         end
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         if (w_capture) begin
            r_src1 <= src1_i;
            r_src2 <= src2_i;
            r_idx  <= w_idx;
         end
         if (w_acc_we) begin
            r_acc[w_acc_widx] <= w_acc_wdata;
         end
      end
   end

endmodule

// File: tb/tb_cfu_mac.sv
// Directed bench for cfu_mac: default instance plus MUL_LAT=1/5 and a 16-bit instance.
module tb_cfu_mac;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_m, en_l1, en_l5, en_x;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] s1, s2;
   logic        stall_m, stall_l1, stall_l5, stall_x;
   logic [31:0] rslt_m, rslt_l1, rslt_l5;
   logic [15:0] rslt_x;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   cfu_mac u_dut (
      .clk_i(clk), .rst_i(rst), .en_i(en_m), .funct3_i(f3), .funct7_i(f7),
      .src1_i(s1), .src2_i(s2), .stall_o(stall_m), .rslt_o(rslt_m)
   );
   cfu_mac #(.MUL_LAT(1)) u_lat1 (
      .clk_i(clk), .rst_i(rst), .en_i(en_l1), .funct3_i(f3), .funct7_i(f7),
      .src1_i(s1), .src2_i(s2), .stall_o(stall_l1), .rslt_o(rslt_l1)
   );
   cfu_mac #(.MUL_LAT(5)) u_lat5 (
      .clk_i(clk), .rst_i(rst), .en_i(en_l5), .funct3_i(f3), .funct7_i(f7),
      .src1_i(s1), .src2_i(s2), .stall_o(stall_l5), .rslt_o(rslt_l5)
   );
   cfu_mac #(.XLEN(16)) u_x16 (
      .clk_i(clk), .rst_i(rst), .en_i(en_x), .funct3_i(f3), .funct7_i(f7),
      .src1_i(s1[15:0]), .src2_i(s2[15:0]), .stall_o(stall_x), .rslt_o(rslt_x)
   );

   function automatic logic sel_stall(input int sel);
      case (sel)
         1:       return stall_l1;
         2:       return stall_l5;
         3:       return stall_x;
         default: return stall_m;
      endcase
   endfunction

   function automatic logic [31:0] sel_rslt(input int sel);
      case (sel)
         1:       return rslt_l1;
         2:       return rslt_l5;
         3:       return {16'h0, rslt_x};
         default: return rslt_m;
      endcase
   endfunction

   task automatic set_en(input int sel, input logic v);
      case (sel)
         1:       en_l1 = v;
         2:       en_l5 = v;
         3:       en_x  = v;
         default: en_m  = v;
      endcase
   endtask

   // Issue one instruction, count stall cycles (bounded), return the completing result.
   task automatic run_op(input int sel, input logic [2:0] op, input int idx,
                         input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output logic [31:0] res);
      @(negedge clk);
      f3 = op;
      f7 = 7'(idx);
      s1 = a;
      s2 = b;
      set_en(sel, 1'b1);
      stalls = 0;
      #1;
      while (sel_stall(sel) === 1'b1 && stalls < 40) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      res = sel_rslt(sel);
      @(negedge clk);
      set_en(sel, 1'b0);
   endtask

   task automatic test_reset();
      int st;
      logic [31:0] r;
      rst = 1'b1;
      en_m = 0; en_l1 = 0; en_l5 = 0; en_x = 0;
      f3 = 0; f7 = 0; s1 = 0; s2 = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (stall_m !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_m); end
      checks++;
      if (rslt_m !== 32'h0) begin errors++; $display("FAIL reset_rslt got %h exp 0", rslt_m); end
      for (int i = 0; i < 4; i++) begin
         run_op(0, 3'd4, i, 32'h0, 32'h0, st, r);
         checks++;
         if (r !== 32'h0) begin errors++; $display("FAIL reset_acc%0d got %h exp 0", i, r); end
      end
   endtask

   task automatic test_or_lanes();
      int st;
      logic [31:0] r;
      run_op(0, 3'd0, 0, 32'h000000F0, 32'h0000000F, st, r);
      checks++;
      if (r !== 32'h000000FF) begin errors++; $display("FAIL or_rslt got %h exp 000000ff", r); end
      checks++;
      if (st !== 0) begin errors++; $display("FAIL or_stall got %0d exp 0", st); end
      run_op(0, 3'd1, 0, 32'h7F01FF80, 32'h01010180, st, r);
      checks++;
      if (r !== 32'h80020000) begin errors++; $display("FAIL padd got %h exp 80020000", r); end
      run_op(0, 3'd2, 0, 32'h7F01FF80, 32'h01010180, st, r);
      checks++;
      if (r !== 32'h7F020080) begin errors++; $display("FAIL psat got %h exp 7f020080", r); end
      run_op(0, 3'd6, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, st, r);
      checks++;
      if (r !== 32'h0 || st !== 0) begin
         errors++; $display("FAIL op6 got %h/%0d exp 0/0", r, st);
      end
   endtask

   task automatic test_dot();
      int st;
      logic [31:0] r;
      run_op(0, 3'd3, 1, 32'h010203FF, 32'h01010102, st, r);
      checks++;
      if (st !== 2) begin errors++; $display("FAIL dot1_stall got %0d exp 2", st); end
      checks++;
      if (r !== 32'd4) begin errors++; $display("FAIL dot1_rslt got %h exp 4", r); end
      run_op(0, 3'd3, 1, 32'h010203FF, 32'h01010102, st, r);
      checks++;
      if (r !== 32'd8) begin errors++; $display("FAIL dot2_rslt got %h exp 8", r); end
      run_op(0, 3'd4, 1, 32'h0, 32'h0, st, r);
      checks++;
      if (r !== 32'd8) begin errors++; $display("FAIL rd_idx1 got %h exp 8", r); end
      run_op(0, 3'd4, 0, 32'h0, 32'h0, st, r);
      checks++;
      if (r !== 32'd0) begin errors++; $display("FAIL rd_idx0 got %h exp 0", r); end
   endtask

   task automatic test_clear();
      int st;
      logic [31:0] r;
      run_op(0, 3'd5, 1, 32'h0, 32'h0, st, r);
      checks++;
      if (r !== 32'd8) begin errors++; $display("FAIL clr_old got %h exp 8", r); end
      run_op(0, 3'd4, 1, 32'h0, 32'h0, st, r);
      checks++;
      if (r !== 32'd0) begin errors++; $display("FAIL clr_after got %h exp 0", r); end
   endtask

   task automatic test_extreme();
      int st;
      logic [31:0] r;
      run_op(0, 3'd3, 2, 32'h80808080, 32'h80808080, st, r);
      checks++;
      if (r !== 32'h00010000) begin errors++; $display("FAIL dot_min got %h exp 00010000", r); end
      // -1 * 2... here -1 * 1 must sign-extend to all ones.
      run_op(0, 3'd3, 3, 32'h000000FF, 32'h00000001, st, r);
      checks++;
      if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL dot_neg got %h exp ffffffff", r); end
      run_op(0, 3'd4, 2, 32'h0, 32'h0, st, r);
      checks++;
      if (r !== 32'h00010000) begin errors++; $display("FAIL rd_idx2 got %h exp 00010000", r); end
   endtask

   task automatic test_flush();
      int st;
      logic [31:0] r;
      @(negedge clk);
      f3 = 3'd3; f7 = 7'd0; s1 = 32'h01010101; s2 = 32'h01010101; en_m = 1'b1;
      #1;
      checks++;
      if (stall_m !== 1'b1) begin errors++; $display("FAIL flush_start got %b exp 1", stall_m); end
      @(negedge clk);
      en_m = 1'b0;
      @(negedge clk);
      f3 = 3'd4; en_m = 1'b1;
      #1;
      checks++;
      if (stall_m !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", stall_m); end
      checks++;
      if (rslt_m !== 32'h0) begin errors++; $display("FAIL flush_rd got %h exp 0", rslt_m); end
      @(negedge clk);
      en_m = 1'b0;
      run_op(0, 3'd4, 0, 32'h0, 32'h0, st, r);
      checks++;
      if (r !== 32'h0) begin errors++; $display("FAIL flush_acc0 got %h exp 0", r); end
   endtask

   task automatic test_back_to_back();
      logic        exp_s [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic        chk_r [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [31:0] exp_r [8] = '{32'd0, 32'd0, 32'd4, 32'd0, 32'd0, 32'd8, 32'd8, 32'd0};
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         case (c)
            0: begin f3 = 3'd3; f7 = 7'd0; s1 = 32'h01010101; s2 = 32'h01010101; en_m = 1; end
            1: s1 = 32'hFFFFFFFF;
            2: s1 = 32'h01010101;
            6: f3 = 3'd4;
            7: en_m = 1'b0;
            default: ;
         endcase
         #1;
         checks++;
         if (stall_m !== exp_s[c]) begin
            errors++; $display("FAIL b2b_stall c%0d got %b exp %b", c, stall_m, exp_s[c]);
         end
         if (chk_r[c]) begin
            checks++;
            if (rslt_m !== exp_r[c]) begin
               errors++; $display("FAIL b2b_rslt c%0d got %h exp %h", c, rslt_m, exp_r[c]);
            end
         end
      end
   endtask

   task automatic test_x16_wrap();
      int st;
      logic [31:0] r;
      run_op(3, 3'd3, 0, 32'h7F7F, 32'h7F7F, st, r);
      checks++;
      if (r !== 32'h7E02 || st !== 2) begin
         errors++; $display("FAIL x16_pre1 got %h/%0d exp 7e02/2", r, st);
      end
      run_op(3, 3'd3, 0, 32'h7F01, 32'h0401, st, r);
      checks++;
      if (r !== 32'h7FFF) begin errors++; $display("FAIL x16_pre2 got %h exp 7fff", r); end
      run_op(3, 3'd3, 0, 32'h0001, 32'h0001, st, r);
      checks++;
      if (r !== 32'h8000) begin errors++; $display("FAIL x16_wrap got %h exp 8000", r); end
   endtask

   task automatic test_lat_sweep();
      int st;
      logic [31:0] r;
      run_op(1, 3'd3, 0, 32'h01010101, 32'h01010101, st, r);
      checks++;
      if (st !== 1 || r !== 32'd4) begin
         errors++; $display("FAIL lat1_a got %0d/%h exp 1/4", st, r);
      end
      run_op(1, 3'd3, 0, 32'h01010101, 32'h01010101, st, r);
      checks++;
      if (st !== 1 || r !== 32'd8) begin
         errors++; $display("FAIL lat1_b got %0d/%h exp 1/8", st, r);
      end
      run_op(2, 3'd3, 0, 32'h01010101, 32'h01010101, st, r);
      checks++;
      if (st !== 5 || r !== 32'd4) begin
         errors++; $display("FAIL lat5 got %0d/%h exp 5/4", st, r);
      end
   endtask

   task automatic test_reset_midop();
      int st;
      logic [31:0] r;
      @(negedge clk);
      f3 = 3'd3; f7 = 7'd2; s1 = 32'h01010101; s2 = 32'h01010101; en_m = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      en_m = 1'b0;
      #1;
      checks++;
      if (stall_m !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %b exp 0", stall_m); end
      for (int i = 0; i < 4; i++) begin
         run_op(0, 3'd4, i, 32'h0, 32'h0, st, r);
         checks++;
         if (r !== 32'h0) begin errors++; $display("FAIL rstmid_acc%0d got %h exp 0", i, r); end
      end
   endtask

   initial begin
      test_reset();
      test_or_lanes();
      test_dot();
      test_clear();
      test_extreme();
      test_flush();
      test_back_to_back();
      test_x16_wrap();
      test_lat_sweep();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
